fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register (pipe1) feeding the decode stage via pipe1PC/pipe1IR.
//   Holds the PC and drives the instruction-memory address.
//   Applies stall and branch/R7 redirect from later stages.
//   Optionally expands LM/SM into one micro-op per selected register, so decode's priority encoder yields the right wA.
// PARAMETERS
//   RESET_PC  16'h0000  PC value after reset
//   NOP_IR    16'hF000  bubble word (opcode 1111 hits the decode default: no reg/mem writes)
// PORTS
//   clk         in   1   clock; all state updates on rising edge
//   reset       in   1   synchronous, active-high reset
//   imemAddr    out  16  instruction-memory address; always equals the PC register
//   imemData    in   16  instruction word at imemAddr; combinational read, valid the same cycle
//   stall       in   1   hazard unit: hold PC, sequencer and pipe1 unchanged
//   redirect    in   1   taken branch/JAL/JLR/R7 write: load PC, squash pipe1
//   redirectPC  in   16  target PC, sampled when redirect=1
//   pipe1PC     out  16  PC of the instruction in pipe1 (LM/SM PC for all its micro-ops)
//   pipe1IR     out  16  instruction/micro-op in pipe1, to decode IR
//   pipe1Valid  out  1   1 = pipe1IR is real work; 0 = bubble
//   seqBusy     out  1   1 while an LM/SM expansion holds the PC (state EXPAND)
// BEHAVIOUR
//   Reset: PC=RESET_PC, pipe1PC=0, pipe1IR=NOP_IR, pipe1Valid=0, state=IDLE, remaining mask=0, seqBusy=0.
//     Reset mid-expansion aborts it.
//   Priority per edge: reset > redirect > stall > normal.
//   Normal (IDLE, non-LM/SM word): pipe1 <= {PC, imemData}, pipe1Valid=1, PC <= PC+1. One instruction per cycle.
//   Fetch-to-decode latency: 1 cycle.
//   Redirect: PC <= redirectPC; pipe1IR=NOP_IR, pipe1PC=0, pipe1Valid=0; state=IDLE, mask cleared.
//     Redirect overrides a simultaneous stall.
//   Stall: PC, pipe1* and sequencer state all hold, including during EXPAND.
//   PC arithmetic: 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000. No carry out.
//   Sequencer (LMSM_SEQ_EN only), states IDLE/EXPAND:
//     Micro-op format: IR[15:9] from the fetched LM/SM word, IR[7:0] = one-hot of the lowest set bit of the mask,
//       IR[8] = 1 only on the last micro-op.
//     IDLE, fetched opcode 0110/0111 with IR[7:0]!=0:
//       Emit the first micro-op and store remaining mask = IR[7:0] with its lowest set bit cleared.
//       If remaining != 0: PC holds, go to EXPAND. Otherwise the emitted op has IR[8]=1 and PC <= PC+1.
//     IDLE, LM/SM with IR[7:0]==0: bubble (NOP_IR, valid=0); PC <= PC+1.
//     EXPAND: imemData ignored. Emit a micro-op for the lowest bit of the remaining mask and clear that bit.
//       On the last bit: IR[8]=1, PC <= PC+1, state <= IDLE.
//     pipe1PC = LM/SM PC for every micro-op; pipe1Valid=1 on every micro-op.
//   seqBusy = (state==EXPAND); it is a registered state decode, not a port of the edge logic.
// CONFIGURATION
//   LMSM_SEQ_EN defined: sequencer above is built. An LM/SM with k set mask bits occupies k pipe1 slots.
//   LMSM_SEQ_EN undefined: no sequencer state. LM/SM words pass through as ordinary words (one slot, PC+1).
//     seqBusy tied 0. Mask-0 LM/SM is passed through unchanged.
// TESTING
//   1 Reset, imem[0..3]=0x0050,0x1283,0x2050,0x3E01, free-run:
//     pipe1PC=0,1,2,3 and pipe1IR matching on cycles 1-4, valid=1.
//   2 stall=1 for 2 cycles while PC=2: imemAddr stays 2, pipe1 holds {1,0x1283}; resumes with PC=2 after release.
//   3 redirect=1, stall=1, redirectPC=0x0040:
//     next cycle pipe1IR=0xF000, valid=0, pipe1PC=0, imemAddr=0x0040.
//   4 LMSM_SEQ_EN, imem[5]=0x6225 (LM R1, mask 0x25):
//     pipe1IR=0x6201, 0x6204, 0x6320 with pipe1PC=5; seqBusy=1 for 2 cycles; then imemAddr=6.
//   5 Same as 4 with redirect to 0x0010 on the 2nd micro-op cycle:
//     bubble, seqBusy=0, no 0x6320 ever emitted, imemAddr=0x0010.
//   6 redirectPC=0xFFFF then free-run: pipe1PC=0xFFFF, then imemAddr=0x0000.
//   6b With LMSM_SEQ_EN, imem[0]=0x7400:
//     bubble, PC=1. Without the macro: pipe1IR=0x7400, valid=1.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register (pipe1).
// Define LMSM_SEQ_EN to build the LM/SM micro-op sequencer.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_IR   = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    output logic [15:0] pipe1PC,
    output logic [15:0] pipe1IR,
    output logic        pipe1Valid,
    output logic        seqBusy
);

    logic [15:0] pc;

    assign imemAddr = pc;

`ifdef LMSM_SEQ_EN
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state;
    logic [7:0]  mask;
    logic [6:0]  hi;
    logic [7:0]  src_mask;
    logic [7:0]  low_bit;
    logic [7:0]  rest_mask;
    logic [6:0]  src_hi;
    logic        is_lmsm;
    logic        emit_uop;

    // The first micro-op comes straight from the fetched word; later ones from the stored mask.
    always_comb begin
        is_lmsm   = (imemData[15:13] == 3'b011);
        src_mask  = (state == EXPAND) ? mask : imemData[7:0];
        src_hi    = (state == EXPAND) ? hi : imemData[15:9];
        low_bit   = src_mask & (~src_mask + 8'd1);
        rest_mask = src_mask & ~low_bit;
        emit_uop  = (state == EXPAND) || (is_lmsm && (imemData[7:0] != '0));
    end

    assign seqBusy = (state == EXPAND);
`else
    assign seqBusy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            pipe1PC    <= '0;
            pipe1IR    <= NOP_IR;
            pipe1Valid <= 1'b0;
`ifdef LMSM_SEQ_EN
            state      <= IDLE;
            mask       <= '0;
            hi         <= '0;
`endif
        end else if (redirect) begin
            pc         <= redirectPC;
            pipe1PC    <= '0;
            pipe1IR    <= NOP_IR;
            pipe1Valid <= 1'b0;
`ifdef LMSM_SEQ_EN
            state      <= IDLE;
            mask       <= '0;
`endif
        end else if (!stall) begin
`ifdef LMSM_SEQ_EN
            if (emit_uop) begin
                pipe1PC    <= pc;
                pipe1IR    <= {src_hi, (rest_mask == '0), low_bit};
                pipe1Valid <= 1'b1;
                mask       <= rest_mask;
                hi         <= src_hi;
                if (rest_mask == '0) begin
                    pc    <= pc + 16'd1;
                    state <= IDLE;
                end else begin
                    state <= EXPAND;
                end
            end else if (is_lmsm) begin
                pc         <= pc + 16'd1;
                pipe1PC    <= '0;
                pipe1IR    <= NOP_IR;
                pipe1Valid <= 1'b0;
            end else begin
                pc         <= pc + 16'd1;
                pipe1PC    <= pc;
                pipe1IR    <= imemData;
                pipe1Valid <= 1'b1;
            end
`else
            pc         <= pc + 16'd1;
            pipe1PC    <= pc;
            pipe1IR    <= imemData;
            pipe1Valid <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: spec vector table, LM/SM sequences, then random run against a queue-based model.
// Honours LMSM_SEQ_EN the same way as the design.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPC;
    logic [15:0] pipe1PC;
    logic [15:0] pipe1IR;
    logic        pipe1Valid;
    logic        seqBusy;

    logic [15:0] imem [0:255];

    int checks   = 0;
    int failures = 0;

`ifdef LMSM_SEQ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    fetch_stage #(.RESET_PC(16'h0000), .NOP_IR(16'hF000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imemAddr   (imemAddr),
        .imemData   (imemData),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .pipe1PC    (pipe1PC),
        .pipe1IR    (pipe1IR),
        .pipe1Valid (pipe1Valid),
        .seqBusy    (seqBusy)
    );

    always_comb imemData = imem[imemAddr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an LM/SM word is unrolled into a list of micro-ops up front.
    logic [15:0] m_pc, m_ppc, m_ir;
    logic        m_v;
    logic        m_ppc_chk;
    logic [15:0] m_q [$];

    task automatic model_step(input logic rst, input logic st, input logic rd, input logic [15:0] rpc);
        logic [15:0] w, u;
        if (rst) begin
            m_pc = 16'h0000; m_ppc = 16'h0000; m_ir = 16'hF000; m_v = 1'b0; m_ppc_chk = 1'b1;
            m_q.delete();
        end else if (rd) begin
            m_pc = rpc; m_ppc = 16'h0000; m_ir = 16'hF000; m_v = 1'b0; m_ppc_chk = 1'b1;
            m_q.delete();
        end else if (!st) begin
            if (m_q.size() == 0) begin
                w = imem[m_pc[7:0]];
                if (SEQ && (w[15:12] == 4'h6 || w[15:12] == 4'h7)) begin
                    if (w[7:0] == 8'h00) begin
                        m_ir = 16'hF000; m_v = 1'b0; m_ppc_chk = 1'b0;
                        m_pc = m_pc + 16'd1;
                        return;
                    end
                    for (int i = 0; i < 8; i++)
                        if (w[i]) begin
                            u = {w[15:9], 1'b0, 8'(1 << i)};
                            m_q.push_back(u);
                        end
                    u = m_q.pop_back();
                    u[8] = 1'b1;
                    m_q.push_back(u);
                end else begin
                    m_ir = w; m_ppc = m_pc; m_v = 1'b1; m_ppc_chk = 1'b1;
                    m_pc = m_pc + 16'd1;
                    return;
                end
            end
            m_ir = m_q.pop_front(); m_ppc = m_pc; m_v = 1'b1; m_ppc_chk = 1'b1;
            if (m_q.size() == 0) m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic st, input logic rd, input logic [15:0] rpc);
        reset = rst; stall = st; redirect = rd; redirectPC = rpc;
        model_step(rst, st, rd, rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string name, input logic [15:0] addr, input logic [15:0] ppc,
                              input logic [15:0] ir, input logic v, input logic busy, input bit chk_ppc);
        check({name, ".addr"}, imemAddr, addr);
        if (chk_ppc) check({name, ".ppc"}, pipe1PC, ppc);
        check({name, ".ir"}, pipe1IR, ir);
        check({name, ".valid"}, {15'd0, pipe1Valid}, {15'd0, v});
        check({name, ".busy"}, {15'd0, seqBusy}, {15'd0, busy});
    endtask

    typedef struct {
        logic        rst, st, rd;
        logic [15:0] rpc;
        logic [15:0] addr, ppc, ir;
        logic        v;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic rst, input logic st, input logic rd, input logic [15:0] rpc,
                                input logic [15:0] addr, input logic [15:0] ppc, input logic [15:0] ir,
                                input logic v);
        vec_t r;
        r.rst = rst; r.st = st; r.rd = rd; r.rpc = rpc;
        r.addr = addr; r.ppc = ppc; r.ir = ir; r.v = v;
        return r;
    endfunction

    initial begin
        logic [15:0] w;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPC = 16'h0000;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[0]    = 16'h0050; imem[1] = 16'h1283; imem[2] = 16'h2050; imem[3] = 16'h3E01;
        imem[5]    = 16'h6225;
        imem[8'h10] = 16'h3333;
        imem[8'h40] = 16'h1111;
        imem[8'hFF] = 16'h2222;

        //             rst  st   rd   rpc       addr      ppc       ir        v
        tbl.push_back(mk(1'b1,1'b0,1'b0,16'h0000, 16'h0000,16'h0000,16'hF000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0001,16'h0000,16'h0050,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h0001,16'h1283,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0003,16'h0002,16'h2050,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0004,16'h0003,16'h3E01,1'b1));
        tbl.push_back(mk(1'b1,1'b0,1'b0,16'h0000, 16'h0000,16'h0000,16'hF000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0001,16'h0000,16'h0050,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h0001,16'h1283,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000, 16'h0002,16'h0001,16'h1283,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000, 16'h0002,16'h0001,16'h1283,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0003,16'h0002,16'h2050,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'h0040, 16'h0040,16'h0000,16'hF000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0041,16'h0040,16'h1111,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b1,16'hFFFF, 16'hFFFF,16'h0000,16'hF000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0000,16'hFFFF,16'h2222,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000, 16'h0001,16'h0000,16'h0050,1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].rd, tbl[i].rpc);
            expect_all($sformatf("vec%0d", i), tbl[i].addr, tbl[i].ppc, tbl[i].ir, tbl[i].v, 1'b0, 1'b1);
        end

        // LM R1 with mask 0x25 at address 5
        cyc(1'b0, 1'b0, 1'b1, 16'h0005);
        expect_all("lm_redir", 16'h0005, 16'h0000, 16'hF000, 1'b0, 1'b0, 1'b1);
`ifdef LMSM_SEQ_EN
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect_all("lm_uop0", 16'h0005, 16'h0005, 16'h6201, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        expect_all("lm_stall", 16'h0005, 16'h0005, 16'h6201, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect_all("lm_uop1", 16'h0005, 16'h0005, 16'h6204, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect_all("lm_uop2", 16'h0006, 16'h0005, 16'h6320, 1'b1, 1'b0, 1'b1);
`else
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect_all("lm_pass", 16'h0006, 16'h0005, 16'h6225, 1'b1, 1'b0, 1'b1);
`endif

        // Redirect landing on the second micro-op cycle aborts the expansion
        cyc(1'b0, 1'b0, 1'b1, 16'h0005);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 16'h0010);
        expect_all("abort_redir", 16'h0010, 16'h0000, 16'hF000, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        expect_all("abort_next", 16'h0011, 16'h0010, 16'h3333, 1'b1, 1'b0, 1'b1);

        // LM/SM with an empty mask
        imem[0] = 16'h7400;
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
`ifdef LMSM_SEQ_EN
        expect_all("mask0", 16'h0001, 16'h0000, 16'hF000, 1'b0, 1'b0, 1'b0);
`else
        expect_all("mask0", 16'h0001, 16'h0000, 16'h7400, 1'b1, 1'b0, 1'b1);
`endif

        // Random phase against the model
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                w[15:13] = 3'b011;
                if ($urandom_range(0, 5) == 0) w[7:0] = 8'h00;
            end
            imem[i] = w;
        end
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int n = 0; n < 3000; n++) begin
            logic r_rst, r_st, r_rd;
            logic [15:0] r_pc;
            r_rst = ($urandom_range(0, 299) == 0);
            r_rd  = ($urandom_range(0, 24) == 0);
            r_st  = ($urandom_range(0, 4) == 0);
            r_pc  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
            cyc(r_rst, r_st, r_rd, r_pc);
            expect_all($sformatf("rnd%0d", n), m_pc, m_ppc, m_ir, m_v, (m_q.size() != 0), m_ppc_chk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
